spi_reg_ctrl: RTL
=================

// Module: spi_reg_ctrl
// PURPOSE
// Byte-level sequencer for the spi_slave shift engine. It turns a chip-select-framed byte stream into 8-bit register bus accesses.
// The first byte of a frame is a command: bit7 = 1 for read, 0 for write; bits[6:0] = start address.
// Later bytes in the frame carry write data or return read data, and the address auto-increments after each byte.
// The block sits between spi_slave (done_o/data_o/data_i/init_i) and the on-chip register file.
// PARAMETERS
// AW      7      register address width, 1..7; command bits above AW-1 are ignored
// STATUS  8'hA5  byte shifted out on MISO while the command byte is received
// PORTS
// clk_i          in   1   system clock, shared with spi_slave
// rst_i          in   1   synchronous reset, active-high
// cs_n_i         in   1   raw SPI chip select (async), synchronised internally by 2 flops
// spi_done_i     in   1   spi_slave done_o: a byte has been received
// spi_rx_data_i  in   8   spi_slave data_o: received byte
// spi_tx_data_o  out  8   to spi_slave data_i: next byte to shift out
// spi_init_o     out  1   to spi_slave init_i: one-cycle acknowledge of done
// reg_wr_en_o    out  1   one-cycle register write strobe
// reg_rd_en_o    out  1   one-cycle register read strobe
// reg_addr_o     out  AW  register address
// reg_wr_data_o  out  8   register write data
// reg_rd_data_i  in   8   read data, valid the cycle after reg_rd_en_o
// busy_o         out  1   high while a frame is active (state != IDLE)
// BEHAVIOUR
// - Reset: all outputs are 0 except spi_tx_data_o = STATUS. State is IDLE and arm = 0.
// - cs_s is cs_n_i after the 2-flop synchroniser. Frame start = cs_s falling; frame end = cs_s high.
// - arm is set whenever cs_s = 1. A frame is accepted only when arm = 1, so a reset in mid-frame ignores the rest of that frame.
// - States and transitions:
//   - IDLE: enter CMD on cs_s = 0 with arm = 1; spi_tx_data_o = STATUS.
//   - CMD: on spi_done_i, latch addr = rx[AW-1:0]. If rx[7] = 1 go to RD, else go to WR.
//   - RD: on entry, and on each later spi_done_i, pulse reg_rd_en_o with the current addr.
//     The next cycle, load spi_tx_data_o <= reg_rd_data_i and set addr <= addr + 1.
//     MOSI bytes received in RD are discarded.
//   - WR: on each spi_done_i, pulse reg_wr_en_o with reg_addr_o = addr and reg_wr_data_o = rx. The next cycle, addr <= addr + 1.
//   - Any state: cs_s = 1 returns to IDLE in the next cycle; spi_tx_data_o <= STATUS.
// - spi_init_o is 1 exactly in the cycle after each spi_done_i is sampled (registered acknowledge). It never stays asserted.
// - Address increments modulo 2^AW: addr = 2^AW-1 wraps to 0 with no flag.
// - Latency:
//   - Write strobe: 1 cycle after spi_done_i.
//   - Read strobe: 1 cycle after spi_done_i (or after the CMD->RD transition).
//   - spi_tx_data_o update: <= 3 cycles after spi_done_i.
//   - System constraint: SCLK half-period >= 4 clk_i.
// - spi_done_i arriving in the same cycle cs_s rises: the byte is still processed (a WR write is issued), then the block goes to IDLE.
// - The last read in a frame prefetches one register beyond the final byte shifted out. This is allowed; reads must be side-effect-free.
// - reg_wr_en_o and reg_rd_en_o are never high in the same cycle. Neither strobe is issued in IDLE or CMD.
// - spi_done_i received in IDLE is acknowledged (spi_init_o) and otherwise ignored.
// TESTING
// 1. Reset, then hold cs high for 4 clk: busy_o = 0, spi_tx_data_o = 8'hA5, no strobes.
// 2. Frame 0x05,0x11,0x22: writes (5,0x11) then (6,0x22). Two reg_wr_en_o pulses; busy_o drops <= 3 clk after cs rises.
// 3. Frame 0x83,xx,xx with regs 3 = 0x3C, 4 = 0x4D: MISO returns A5,3C,4D; reg_rd_en_o at addr 3, 4, 5.
// 4. Wrap: write command 0x7F followed by 2 data bytes: writes land at addr 127, then 0.
// 5. Assert rst_i mid-write frame: no further reg_wr_en_o until cs goes high and then low; the next frame parses its first byte as a command.
// 6. spi_done_i in the same cycle as cs rising in WR: the write is still issued, then IDLE; spi_init_o is a single pulse for each done.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: byte-level sequencer between spi_slave and an 8-bit register file.
// The first byte of a chip-select frame is a command (bit7 = read, low bits = start address).
// Each following byte is written to, or read from, an auto-incrementing register address.
module spi_reg_ctrl #(
    parameter int unsigned AW     = 7,
    parameter logic [7:0]  STATUS = 8'hA5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cs_n_i,
    input  logic          spi_done_i,
    input  logic [7:0]    spi_rx_data_i,
    output logic [7:0]    spi_tx_data_o,
    output logic          spi_init_o,
    output logic          reg_wr_en_o,
    output logic          reg_rd_en_o,
    output logic [AW-1:0] reg_addr_o,
    output logic [7:0]    reg_wr_data_o,
    input  logic [7:0]    reg_rd_data_i,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_RD,
        ST_WR
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic          cs_meta_q;
    logic          cs_s_q;
    logic          arm_q;
    logic          rd_pend_q;
    logic [AW-1:0] addr_q;

    logic          wr_en_d;
    logic          rd_en_d;
    logic          addr_load_d;

    // Two-flop synchroniser for the asynchronous chip select. The flops clear
    // to 0 so that a reset taken mid-frame (cs still low) never sees a
    // spurious high level and re-arms before the frame really ends.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cs_meta_q <= 1'b0;
            cs_s_q    <= 1'b0;
        end else begin
            cs_meta_q <= cs_n_i;
            cs_s_q    <= cs_meta_q;
        end
    end

    // Arm once chip select is seen idle; a frame already in progress at reset is ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            arm_q <= 1'b0;
        end else if (cs_s_q) begin
            arm_q <= 1'b1;
        end
    end

    // Frame state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-byte decisions. A write byte that arrives together
    // with the rising chip select is still committed; a read strobe is not
    // started once the frame is ending.
    always_comb begin
        state_d     = state_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        addr_load_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!cs_s_q && arm_q) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (spi_done_i && !cs_s_q) begin
                    addr_load_d = 1'b1;
                    if (spi_rx_data_i[7]) begin
                        state_d = ST_RD;
                        rd_en_d = 1'b1;
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_RD: begin
                if (spi_done_i && !cs_s_q) begin
                    rd_en_d = 1'b1;
                end
            end
            ST_WR: begin
                if (spi_done_i) begin
                    wr_en_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (cs_s_q) begin
            state_d = ST_IDLE;
        end
    end

    // Registered strobes, acknowledge, address counter and MISO byte.
    // The address advances in the cycle after each strobe, so the strobe
    // cycle always presents the address that was current when the byte landed.
    // Read data is captured one cycle after the read strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spi_init_o    <= 1'b0;
            reg_wr_en_o   <= 1'b0;
            reg_rd_en_o   <= 1'b0;
            rd_pend_q     <= 1'b0;
            addr_q        <= '0;
            reg_wr_data_o <= '0;
            spi_tx_data_o <= STATUS;
        end else begin
            spi_init_o  <= spi_done_i;
            reg_wr_en_o <= wr_en_d;
            reg_rd_en_o <= rd_en_d;
            rd_pend_q   <= reg_rd_en_o;
            if (wr_en_d) begin
                reg_wr_data_o <= spi_rx_data_i;
            end
            if (addr_load_d) begin
                addr_q <= spi_rx_data_i[AW-1:0];
            end else if (reg_wr_en_o || reg_rd_en_o) begin
                addr_q <= addr_q + 1'b1;
            end
            if (cs_s_q) begin
                spi_tx_data_o <= STATUS;
            end else if (rd_pend_q) begin
                spi_tx_data_o <= reg_rd_data_i;
            end
        end
    end

    assign reg_addr_o = addr_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule
